fault_sim_sequencer: RTL and testbench
======================================

// Module: fault_sim_sequencer
// PURPOSE
//  Hardware stuck-at fault-grading controller for a small combinational DUT.
//  - Walks the full fault list: stuck-at-0/1 on every DUT net.
//  - For each fault, applies the exhaustive input pattern set to a good DUT copy and a fault-injected DUT copy.
//  - Compares the two responses and reports per fault: detected or undetected, plus the first detecting pattern.
//  - Sits between the pattern/fault bookkeeping and the DUT pair in the fault-simulation flow.
// PARAMETERS
//  NUM_IN   2   DUT primary inputs; pattern space is 2**NUM_IN
//  NUM_NET  3   DUT nets eligible for injection; inputs first (index 0..NUM_IN-1), then internal/output nets
//  NET_W    2   width of net index, >= clog2(NUM_NET)
//  FID_W    3   fault id width, = NET_W+1; fault id = {net_idx, sa_val}
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous active-low reset
//  start         in   1        pulse: begin a grading run (honoured only in IDLE)
//  abort         in   1        synchronous: cancel the run
//  busy          out  1        high from the cycle after start until DONE/abort
//  done          out  1        one-cycle pulse at the end of a completed run
//  pat_out       out  NUM_IN   registered pattern to both DUT copies, MSB = input 0
//  flt_en        out  1        enables injection on the faulty copy
//  flt_net       out  NET_W    net to force
//  flt_val       out  1        forced value
//  good_resp     in   1        good-copy output (combinational from pat_out)
//  fault_resp    in   1        faulty-copy output (combinational from pat_out/flt_*)
//  res_valid     out  1        result available
//  res_ready     in   1        consumer accepts the result
//  res_fault_id  out  FID_W    fault being reported
//  res_detected  out  1        1 = some pattern produced a mismatch
//  res_pattern   out  NUM_IN   first detecting pattern; 0 when undetected
//  det_count     out  FID_W+1  detected faults in the current run
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (busy, done, flt_en, res_valid, pat_out, flt_net, flt_val, res_*, det_count).
//  - FSM states: IDLE, SETUP, APPLY, EVAL, REPORT, DONE.
//  - IDLE: on start, clear det_count and fault id to 0, go to SETUP; busy=1.
//  - SETUP: drive flt_net=fid[FID_W-1:1], flt_val=fid[0], flt_en=1; pat_out=0; go to APPLY.
//  - APPLY: pattern held one cycle so the DUT settles; go to EVAL.
//  - EVAL: sample good_resp ^ fault_resp.
//    - Mismatch: latch res_detected=1 and res_pattern=pat_out; det_count++; go to REPORT. Fault dropping: no further patterns.
//    - Match, pat_out == all-ones: res_detected=0, res_pattern=0; go to REPORT.
//    - Otherwise: pat_out++ and go to APPLY.
//  - REPORT: res_valid=1, res_* stable until res_valid&&res_ready.
//    - On handshake: if fid == 2*NUM_NET-1, go to DONE; else fid++ and go to SETUP.
//    - res_ready already high on entry: handshake completes in that first REPORT cycle.
//  - DONE: done=1 for one cycle, flt_en=0, busy=0 next cycle; go to IDLE. det_count holds until the next start.
//  - Timing per fault: 1 (SETUP) + 2*k (k = patterns applied) + 1 or more (REPORT).
//    - Exhaustive undetected fault: 2 + 2**(NUM_IN+1) cycles minimum.
//  - pat_out never wraps: the last pattern always terminates through REPORT.
//  - start while busy: ignored.
//  - abort in any non-IDLE state: next cycle IDLE; res_valid, flt_en, busy drop; no done; det_count keeps its partial value.
//  - abort and start together in IDLE: abort wins, no run.
//  - rst_n low mid-run: immediate return to reset values; no done or result is emitted.
// STRUCTURE
//  - Shared package fsim_pkg:
//    - state enum fsim_state_e.
//    - typedef fault_id_t, {net_idx, sa_val}.
//    - constants SA0 = 1'b0, SA1 = 1'b1.
//  - One sub-module, fsim_pat_counter: NUM_IN-bit pattern register with clear, increment and is_last flag.
//  - The FSM, fault-id counter and result registers stay in fault_sim_sequencer.
// TESTING (NUM_IN=2, NUM_NET=3; DUT = 2-input AND; nets a=0, b=1, o=2; pat_out={a,b})
//  1. Full run, res_ready tied 1 -> in order:
//     - ids 0..5 report detected=1 with patterns 3, 1, 3, 2, 3, 0.
//     - det_count=6, then one done pulse.
//  2. id 0 (a sa0) -> res_valid rises 9 cycles after SETUP entry (patterns 0..3 applied).
//  3. Faulty copy tied equal to good copy -> all 6 report detected=0, res_pattern=0, det_count=0.
//  4. res_ready low for 5 cycles on id 3 -> res_* stable and pat_out frozen; SETUP for id 4 follows the cycle after res_ready rises.
//  5. abort during EVAL of id 2 -> next cycle IDLE, busy=0, res_valid=0, no done, det_count=2.
//  6. rst_n pulsed low mid-APPLY -> all outputs 0 asynchronously; a fresh start reruns from id 0.

Source files
------------

// File: rtl/fsim_pkg.sv
// rtl/fsim_pkg.sv - shared types and constants for the stuck-at fault-grading sequencer
// Contents:
//   DEF_*        default geometry (2-input DUT, 3 injectable nets)
//   SA0 / SA1    stuck-at values
//   fsim_state_e sequencer FSM states
//   fault_id_t   fault id layout {net_idx, sa_val}
package fsim_pkg;

  localparam int DEF_NUM_IN  = 2;
  localparam int DEF_NUM_NET = 3;
  localparam int DEF_NET_W   = 2;
  localparam int DEF_FID_W   = DEF_NET_W + 1;

  localparam logic SA0 = 1'b0;
  localparam logic SA1 = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_APPLY,
    S_EVAL,
    S_REPORT,
    S_DONE
  } fsim_state_e;

  typedef struct packed {
    logic [DEF_NET_W-1:0] net_idx;
    logic                 sa_val;
  } fault_id_t;

endpackage

// File: rtl/fault_sim_sequencer_if.sv
// rtl/fault_sim_sequencer_if.sv - control, DUT-pair and result signals of the fault-grading sequencer
// Signals:
//   start/abort/busy/done       run control
//   pat_out, flt_en/net/val     drive to the good and faulty DUT copies
//   good_resp, fault_resp       DUT copy responses
//   res_valid/res_ready, res_*  per-fault result channel
//   det_count                   detected faults in the current run
// Modports: slave = sequencer, master = environment driving it.
interface fault_sim_sequencer_if
  import fsim_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int NET_W  = DEF_NET_W,
  parameter int FID_W  = DEF_FID_W
) ();

  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [NUM_IN-1:0] pat_out;
  logic              flt_en;
  logic [NET_W-1:0]  flt_net;
  logic              flt_val;
  logic              good_resp;
  logic              fault_resp;
  logic              res_valid;
  logic              res_ready;
  logic [FID_W-1:0]  res_fault_id;
  logic              res_detected;
  logic [NUM_IN-1:0] res_pattern;
  logic [FID_W:0]    det_count;

  modport slave (
    input  start, abort, good_resp, fault_resp, res_ready,
    output busy, done, pat_out, flt_en, flt_net, flt_val,
           res_valid, res_fault_id, res_detected, res_pattern, det_count
  );

  modport master (
    output start, abort, good_resp, fault_resp, res_ready,
    input  busy, done, pat_out, flt_en, flt_net, flt_val,
           res_valid, res_fault_id, res_detected, res_pattern, det_count
  );

endinterface

// File: rtl/fsim_pat_counter.sv
// rtl/fsim_pat_counter.sv - exhaustive input-pattern register for one fault
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clr        load pattern 0 (has priority over i_inc)
//   i_inc        advance to the next pattern; saturates at all-ones
//   o_pat        current pattern
//   o_is_last    current pattern is all-ones
module fsim_pat_counter
  import fsim_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [NUM_IN-1:0] o_pat,
  output logic              o_is_last
);

  logic [NUM_IN-1:0] r_pat;
  logic              w_is_last;

  assign w_is_last = &r_pat;

  // Saturating so the pattern can never wrap back to 0 within a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat <= '0;
    end else if (i_clr) begin
      r_pat <= '0;
    end else if (i_inc && !w_is_last) begin
      r_pat <= r_pat + 1'b1;
    end
  end

  assign o_pat     = r_pat;
  assign o_is_last = w_is_last;

endmodule

// File: rtl/fault_sim_sequencer.sv
// rtl/fault_sim_sequencer.sv - stuck-at fault-grading controller for a small combinational DUT
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fault_sim_sequencer_if.slave: run control, DUT-pair drive/response,
//          per-fault result channel and detected-fault count
// Walks fault ids 0..2*NUM_NET-1 ({net, stuck value}); for each one applies
// patterns 0..2**NUM_IN-1 until the good and faulty copies disagree, then
// reports the fault and its first detecting pattern.
module fault_sim_sequencer
  import fsim_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int NUM_NET = DEF_NUM_NET,
  parameter int NET_W   = DEF_NET_W,
  parameter int FID_W   = DEF_FID_W
) (
  input logic            clk,
  input logic            rst_n,
  fault_sim_sequencer_if.slave bus
);

  localparam logic [FID_W-1:0] LAST_FID = FID_W'(2 * NUM_NET - 1);

  fsim_state_e       r_state;
  fsim_state_e       w_next;

  logic [FID_W-1:0]  r_fid;
  logic              r_det;
  logic [NUM_IN-1:0] r_res_pat;
  logic [FID_W:0]    r_det_count;

  logic [NUM_IN-1:0] w_pat;
  logic              w_pat_last;
  logic              w_pat_clr;
  logic              w_pat_inc;
  logic              w_mismatch;
  logic              w_last_fault;
  logic              w_flt_en;

  assign w_mismatch   = bus.good_resp ^ bus.fault_resp;
  assign w_last_fault = (r_fid == LAST_FID);

  // Pattern restarts at 0 whenever a new fault is set up or the run ends;
  // it is left untouched while a result waits in REPORT.
  assign w_pat_clr = (w_next == S_SETUP) || (w_next == S_IDLE);
  assign w_pat_inc = (r_state == S_EVAL) && (w_next == S_APPLY);

  fsim_pat_counter #(
    .NUM_IN (NUM_IN)
  ) u_pat_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_pat_clr),
    .i_inc     (w_pat_inc),
    .o_pat     (w_pat),
    .o_is_last (w_pat_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort overrides everything, including start in IDLE.
  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.start) w_next = S_SETUP;
        S_SETUP:  w_next = S_APPLY;
        S_APPLY:  w_next = S_EVAL;
        S_EVAL:   w_next = (w_mismatch || w_pat_last) ? S_REPORT : S_APPLY;
        S_REPORT: if (bus.res_ready) w_next = w_last_fault ? S_DONE : S_SETUP;
        S_DONE:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Fault id, result and detection-count registers. Frozen on abort so the
  // partial det_count survives the cancelled run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fid       <= '0;
      r_det       <= 1'b0;
      r_res_pat   <= '0;
      r_det_count <= '0;
    end else if (!bus.abort) begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_fid       <= '0;
            r_det       <= 1'b0;
            r_res_pat   <= '0;
            r_det_count <= '0;
          end
        end
        S_EVAL: begin
          if (w_mismatch) begin
            r_det       <= 1'b1;
            r_res_pat   <= w_pat;
            r_det_count <= r_det_count + 1'b1;
          end else if (w_pat_last) begin
            r_det       <= 1'b0;
            r_res_pat   <= '0;
          end
        end
        S_REPORT: begin
          if (bus.res_ready && !w_last_fault) begin
            r_fid <= r_fid + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_flt_en = (r_state == S_SETUP) || (r_state == S_APPLY) ||
                    (r_state == S_EVAL)  || (r_state == S_REPORT);

  // Output logic
  always_comb begin
    bus.busy         = (r_state != S_IDLE);
    bus.done         = (r_state == S_DONE);
    bus.flt_en       = w_flt_en;
    // Injection target reads as 0 whenever injection is off.
    bus.flt_net      = w_flt_en ? r_fid[FID_W-1:1] : '0;
    bus.flt_val      = w_flt_en ? r_fid[0] : 1'b0;
    bus.pat_out      = w_pat;
    bus.res_valid    = (r_state == S_REPORT);
    bus.res_fault_id = r_fid;
    bus.res_detected = r_det;
    bus.res_pattern  = r_res_pat;
    bus.det_count    = r_det_count;
  end

endmodule

// File: tb/tb_fault_sim_sequencer.sv
// tb/tb_fault_sim_sequencer.sv - self-checking bench for fault_sim_sequencer with a 2-input AND DUT pair
module tb_fault_sim_sequencer;
  import fsim_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fault_sim_sequencer_if bus ();

  fault_sim_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // DUT pair: o = a & b, nets a=0, b=1, o=2, pat_out = {a, b}.
  bit   tie_equal;
  logic m_a, m_b, m_fa, m_fb, m_fo;
  always_comb begin
    m_a  = bus.pat_out[1];
    m_b  = bus.pat_out[0];
    m_fa = (bus.flt_en && bus.flt_net == 2'd0) ? bus.flt_val : m_a;
    m_fb = (bus.flt_en && bus.flt_net == 2'd1) ? bus.flt_val : m_b;
    m_fo = m_fa & m_fb;
    if (bus.flt_en && bus.flt_net == 2'd2) m_fo = bus.flt_val;
    bus.good_resp  = m_a & m_b;
    bus.fault_resp = tie_equal ? (m_a & m_b) : m_fo;
  end

  typedef struct {
    logic [2:0] id;
    logic       det;
    logic [1:0] pat;
  } vec_t;
  vec_t tbl[6];

  int n_tests;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("res_valid_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits for the result of table entry idx, checks it, optionally holds
  // res_ready low for `hold` cycles, then lets the handshake complete.
  task automatic check_fault(input int idx, input bit undet, input bit pulse, input int hold);
    bit         ok;
    int         cyc;
    logic [1:0] e_pat;
    logic       e_det;
    logic [1:0] e_frozen;
    wait_valid(ok, cyc);
    if (ok) begin
      e_det    = undet ? 1'b0 : tbl[idx].det;
      e_pat    = undet ? 2'd0 : tbl[idx].pat;
      e_frozen = undet ? 2'd3 : tbl[idx].pat;
      chk($sformatf("fault%0d_id", idx), bus.res_fault_id, tbl[idx].id);
      chk($sformatf("fault%0d_det", idx), bus.res_detected, e_det);
      chk($sformatf("fault%0d_pat", idx), bus.res_pattern, e_pat);
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        chk("hold_valid", bus.res_valid, 1'b1);
        chk("hold_id", bus.res_fault_id, tbl[idx].id);
        chk("hold_det", bus.res_detected, e_det);
        chk("hold_pat", bus.res_pattern, e_pat);
        chk("hold_pat_out", bus.pat_out, e_frozen);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      if (pulse) bus.res_ready = 1'b0;
      if (hold > 0) begin
        chk("next_setup_valid", bus.res_valid, 1'b0);
        chk("next_setup_flt_en", bus.flt_en, 1'b1);
        chk("next_setup_flt_net", bus.flt_net, tbl[idx + 1].id[2:1]);
        chk("next_setup_flt_val", bus.flt_val, tbl[idx + 1].id[0]);
        chk("next_setup_pat_out", bus.pat_out, 2'd0);
      end
    end
  endtask

  task automatic check_done(input int exp_cnt);
    chk("done_pulse", bus.done, 1'b1);
    chk("done_busy", bus.busy, 1'b1);
    chk("done_flt_en", bus.flt_en, 1'b0);
    chk("done_det_count", bus.det_count, exp_cnt);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_det_count", bus.det_count, exp_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int cyc;
    int seen;
    n_tests = 0;
    n_fail  = 0;
    tbl[0] = '{3'd0, 1'b1, 2'd3};
    tbl[1] = '{3'd1, 1'b1, 2'd1};
    tbl[2] = '{3'd2, 1'b1, 2'd3};
    tbl[3] = '{3'd3, 1'b1, 2'd2};
    tbl[4] = '{3'd4, 1'b1, 2'd3};
    tbl[5] = '{3'd5, 1'b1, 2'd0};
    tie_equal     = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.res_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_flt_en", bus.flt_en, 1'b0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_pat_out", bus.pat_out, 2'd0);
    chk("rst_det_count", bus.det_count, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full run, res_ready tied high; id 0 latency from SETUP entry
    bus.res_ready = 1'b1;
    start_run();
    chk("setup_busy", bus.busy, 1'b1);
    chk("setup_flt_en", bus.flt_en, 1'b1);
    chk("setup_flt_val", bus.flt_val, SA0);
    chk("setup_pat_out", bus.pat_out, 2'd0);
    wait_valid(ok, cyc);
    chk("id0_latency", cyc, 9);
    for (int i = 0; i < 6; i++) check_fault(i, 1'b0, 1'b0, 0);
    check_done(6);

    // Faulty copy identical to good copy: nothing detected
    tie_equal = 1'b1;
    start_run();
    for (int i = 0; i < 6; i++) check_fault(i, 1'b1, 1'b0, 0);
    check_done(0);
    tie_equal = 1'b0;

    // Backpressure on id 3
    bus.res_ready = 1'b0;
    start_run();
    for (int i = 0; i < 6; i++) check_fault(i, 1'b0, 1'b1, (i == 3) ? 5 : 0);
    check_done(6);

    // Abort during the first EVAL of id 2
    bus.res_ready = 1'b1;
    start_run();
    check_fault(0, 1'b0, 1'b0, 0);
    check_fault(1, 1'b0, 1'b0, 0);
    chk("id2_setup_flt_net", bus.flt_net, 2'd1);
    chk("id2_setup_flt_val", bus.flt_val, SA0);
    @(negedge clk);
    @(negedge clk);
    chk("id2_eval_pat_out", bus.pat_out, 2'd0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_res_valid", bus.res_valid, 1'b0);
    chk("abort_flt_en", bus.flt_en, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_det_count", bus.det_count, 4'd2);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    chk("abort_quiet", seen, 0);

    // start and abort together in IDLE: no run
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", bus.busy, 1'b0);
    chk("start_abort_det_count", bus.det_count, 4'd2);

    // Asynchronous reset mid-APPLY of id 1, then a fresh run
    start_run();
    check_fault(0, 1'b0, 1'b0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_flt_en", bus.flt_en, 1'b0);
    chk("arst_flt_val", bus.flt_val, 1'b0);
    chk("arst_det_count", bus.det_count, 4'd0);
    chk("arst_res_fault_id", bus.res_fault_id, 3'd0);
    chk("arst_pat_out", bus.pat_out, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_no_done", bus.done, 1'b0);
    start_run();
    chk("rerun_flt_val", bus.flt_val, SA0);
    chk("rerun_flt_net", bus.flt_net, 2'd0);
    for (int i = 0; i < 6; i++) check_fault(i, 1'b0, 1'b0, 0);
    check_done(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
